key_parser_out: RTL and testbench



---
 rtl/key_parser_pkg.sv | 26 ++
 rtl/key_parser_out.sv | 128 ++++++++++++
 tb/tb_key_parser_out.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/key_parser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : key_parser_pkg                                          |
// | Purpose  : Shared constants, state encoding and word-count helper  |
// |            for the masked-value serial unloader key_parser_out.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package key_parser_pkg;

  localparam int WORD_W          = 32;
  localparam int SHARE_W         = 128;
  localparam int WORDS_PER_SHARE = SHARE_W / WORD_W;

  // IDLE waits for a capture request, SEND streams the buffer out
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of 32-bit words emitted for a d-share value
  function automatic int total_words(input int d);
    return WORDS_PER_SHARE * d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_parser_out.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : key_parser_out                                          |
// | Purpose  : Captures a 128*D-bit shared value and unloads it as     |
// |            32-bit words under a valid/ready handshake, in the      |
// |            inverse order of the 32-bit key/share serial loader.    |
// | Option   : KEY_PARSER_OUT_ZEROIZE_EN - buffer shifts in zeros and  |
// |            sdo reads 0 while not valid (no share residue).         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module key_parser_out
  import key_parser_pkg::*;
#(
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SHARE_W*D-1:0] i_data,
  input  logic                 i_load,
  output logic [WORD_W-1:0]    o_sdo,
  output logic                 o_sdo_valid,
  input  logic                 i_sdo_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BUF_W   = SHARE_W * D;
  localparam int N_WORDS = total_words(D);
  localparam int CNT_W   = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_WORDS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUF_W-1:0]   r_buf;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORD_W-1:0]  r_sdo;
  logic               r_done;

  logic [BUF_W-1:0]   w_reord;
  logic [BUF_W-1:0]   w_buf_shift;
  logic [WORD_W-1:0]  w_next_top;
  logic               w_start;
  logic               w_hs;
  logic               w_last;

  // Reorder network: emission slot k sits at the top of the buffer minus 32*k.
  // Slot k walks word index w from 3 down to 0, and shares D-1 down to 0 within each w.
  for (genvar w = 0; w < WORDS_PER_SHARE; w++) begin : g_word
    for (genvar s = 0; s < D; s++) begin : g_share
      localparam int K = (WORDS_PER_SHARE - 1 - w) * D + (D - 1 - s);
      assign w_reord[BUF_W-1-WORD_W*K -: WORD_W] = i_data[SHARE_W*s + WORD_W*w +: WORD_W];
    end
  end

  // Word that becomes visible after the current one is accepted
  assign w_next_top = r_buf[BUF_W-WORD_W-1 -: WORD_W];

`ifdef KEY_PARSER_OUT_ZEROIZE_EN
  assign w_buf_shift = {r_buf[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
`else
  assign w_buf_shift = {r_buf[BUF_W-WORD_W-1:0], r_buf[BUF_W-1 -: WORD_W]};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus start / handshake / final-word strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_hs        = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load) begin
          w_start     = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_hs = i_sdo_ready;
        if (i_sdo_ready && (r_cnt == C_LAST)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Buffer capture/shift, word counter, output word register and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_cnt  <= '0;
      r_sdo  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_buf <= w_reord;
        r_cnt <= '0;
        r_sdo <= w_reord[BUF_W-1 -: WORD_W];
      end else if (w_hs) begin
        r_buf <= w_buf_shift;
        // Counter parks on the final index instead of wrapping; load clears it
        if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
`ifdef KEY_PARSER_OUT_ZEROIZE_EN
        if (w_last) r_sdo <= '0;
        else        r_sdo <= w_next_top;
`else
        // The last emitted word stays on sdo once the transfer ends
        if (!w_last) r_sdo <= w_next_top;
`endif
      end
    end
  end

  assign o_sdo       = r_sdo;
  assign o_sdo_valid = (r_state == SEND);
  assign o_busy      = (r_state == SEND);
  assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_key_parser_out.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_key_parser_out                                       |
// | Purpose  : Directed self-checking bench for key_parser_out (D=2).  |
// |            Honours KEY_PARSER_OUT_ZEROIZE_EN when defined.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_key_parser_out;

  localparam int D = 2;

  logic         clk;
  logic         rst_n;
  logic [255:0] i_data;
  logic         i_load;
  logic [31:0]  o_sdo;
  logic         o_sdo_valid;
  logic         i_sdo_ready;
  logic         o_busy;
  logic         o_done;

  int n_checks;
  int n_errors;

  key_parser_out #(.D(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (i_data),
    .i_load      (i_load),
    .o_sdo       (o_sdo),
    .o_sdo_valid (o_sdo_valid),
    .i_sdo_ready (i_sdo_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before driving/sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Data set 1 (test plan values) and its expected word stream
  localparam logic [127:0] C_S0_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] C_S1_A = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  // Data set 2 (distinct pattern) for load-while-busy and back-to-back
  localparam logic [127:0] C_S0_B = 128'h01010101_02020202_03030303_04040404;
  localparam logic [127:0] C_S1_B = 128'h10101010_20202020_30303030_40404040;

  logic [31:0]  exp_a [8];
  logic [31:0]  exp_b [8];
  logic [255:0] data_a;
  logic [255:0] data_b;
  logic [255:0] rebuilt;
  logic [255:0] exp_buf;
  logic [3:0]   ready_pat;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    data_a    = {C_S1_A, C_S0_A};
    data_b    = {C_S1_B, C_S0_B};
    exp_a     = '{32'hFFEEDDCC, 32'h00112233, 32'hBBAA9988, 32'h44556677,
                  32'h77665544, 32'h8899AABB, 32'h33221100, 32'hCCDDEEFF};
    exp_b     = '{32'h10101010, 32'h01010101, 32'h20202020, 32'h02020202,
                  32'h30303030, 32'h03030303, 32'h40404040, 32'h04040404};
    ready_pat = 4'b1001; // bit i used on cycle i%4: 1,0,0,1
    rebuilt   = '0;

    rst_n       = 1'b0;
    i_load      = 1'b0;
    i_data      = '0;
    i_sdo_ready = 1'b1;

    // ---------------- reset state ----------------
    step();
    chk("rst_sdo",   {224'd0, o_sdo},       256'd0);
    chk("rst_valid", {255'd0, o_sdo_valid}, 256'd0);
    chk("rst_busy",  {255'd0, o_busy},      256'd0);
    chk("rst_done",  {255'd0, o_done},      256'd0);
    rst_n = 1'b1;
    step();
    // ready high while idle must not start anything
    chk("idle_ready_valid", {255'd0, o_sdo_valid}, 256'd0);

    // ---------------- basic transfer + loopback ----------------
    i_data = data_a;
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("basic_busy", {255'd0, o_busy}, 256'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("basic_w%0d", i), {224'd0, o_sdo}, {224'd0, exp_a[i]});
      chk($sformatf("basic_v%0d", i), {254'd0, o_sdo_valid, o_done}, 256'd2);
      // Serial loader model: slot i carries share D-1-i%D, word 3-i/D
      rebuilt[128*(D-1-(i%D)) + 32*(3-(i/D)) +: 32] = o_sdo;
      step();
    end
    chk("basic_done",   {255'd0, o_done},      256'd1);
    chk("basic_idle_v", {255'd0, o_sdo_valid}, 256'd0);
    chk("basic_idle_b", {255'd0, o_busy},      256'd0);
    chk("loopback",     rebuilt,               data_a);
`ifdef KEY_PARSER_OUT_ZEROIZE_EN
    exp_buf = '0;
    chk("idle_sdo", {224'd0, o_sdo}, 256'd0);
`else
    exp_buf = {exp_a[0], exp_a[1], exp_a[2], exp_a[3],
               exp_a[4], exp_a[5], exp_a[6], exp_a[7]};
    chk("idle_sdo", {224'd0, o_sdo}, {224'd0, exp_a[7]});
`endif
    chk("buf_after", dut.r_buf, exp_buf);
    step();
    chk("done_one_cycle", {255'd0, o_done}, 256'd0);

    // ---------------- backpressure ----------------
    i_data = data_a;
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    begin
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 64) begin
        i_sdo_ready = ready_pat[cyc % 4];
        chk($sformatf("bp_c%0d", cyc), {223'd0, o_sdo_valid, o_sdo}, {223'd0, 1'b1, exp_a[idx]});
        chk($sformatf("bp_d%0d", cyc), {255'd0, o_done}, 256'd0);
        if (i_sdo_ready) idx++;
        cyc++;
        step();
      end
      chk("bp_timeout", 256'(idx), 256'd8);
    end
    i_sdo_ready = 1'b1;
    chk("bp_done", {255'd0, o_done}, 256'd1);
    step();

    // ---------------- load while busy, then back-to-back ----------------
    i_data = data_a;
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lwb_w%0d", i), {224'd0, o_sdo}, {224'd0, exp_a[i]});
      if (i == 2) begin
        i_data = data_b;
        i_load = 1'b1;
      end else begin
        i_load = 1'b0;
      end
      step();
    end
    chk("lwb_done", {255'd0, o_done}, 256'd1);
    // Load in the done cycle starts the next transfer immediately
    i_data = data_b;
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_w%0d", i), {223'd0, o_sdo_valid, o_sdo}, {223'd0, 1'b1, exp_b[i]});
      step();
    end
    chk("b2b_done", {255'd0, o_done}, 256'd1);
    step();

    // ---------------- reset mid-transfer ----------------
    i_data = data_a;
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    step();
    step();
    step(); // three words accepted
    chk("pre_rst_w3", {224'd0, o_sdo}, {224'd0, exp_a[3]});
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {221'd0, o_sdo_valid, o_busy, o_done, o_sdo}, 256'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_done", {255'd0, o_done}, 256'd0);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("restart_w0", {223'd0, o_sdo_valid, o_sdo}, {223'd0, 1'b1, exp_a[0]});
    step();
    chk("restart_w1", {224'd0, o_sdo}, {224'd0, exp_a[1]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
